// File: rtl/alu_share_arb.sv
// alu_share_arb
//   Arbiter/sequencer in front of the shared 32-bit combinational ALU.
//   Two requesters (0: fetch path, 1: execute path) offer operations over
//   valid/ready. One operation is granted at a time: the operands are latched,
//   the ALU is evaluated for exactly one cycle (EXEC), and the result/flags
//   are held on the response port until the consumer takes them (RESP).
//
//   Ports
//     clk, reset            clock, synchronous active-low reset
//     req{0,1}_valid/_a/_b/_ctrl/_ready   requester handshakes
//       ctrl: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MUL, 101-111 illegal
//     alu_a/_b/_ctrl        operands/op to the ALU (from op registers)
//     alu_result/_flags     ALU result and flags {N,Z,C,V}
//     rsp_valid/_ready      response handshake
//     rsp_id/_result/_flags/_err   captured response
//
//   Build option
//     ALU_SHARE_RR_EN  defined: round-robin on contention.
//                      undefined: requester 0 has fixed priority.
module alu_share_arb (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_ctrl,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_ctrl,
  output logic        req1_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_ctrl,
  input  logic [31:0] alu_result,
  input  logic [3:0]  alu_flags,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic        rsp_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic        id;
    logic [2:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
  } op_t;

  state_t state_q, state_d;
  op_t    op_q;
  logic   accept, gnt_vld, gnt_id, op_illegal;

`ifdef ALU_SHARE_RR_EN
  // Grant history only matters for round-robin.
  logic   last_grant_q;
`endif

  // RESP with rsp_ready doubles as an accept point, giving one op per 2 cycles.
  assign accept  = (state_q == IDLE) || ((state_q == RESP) && rsp_ready);
  // reset gates the grant so no ready is shown while reset is held.
  assign gnt_vld = reset && accept && (req0_valid || req1_valid);

  always_comb begin
`ifdef ALU_SHARE_RR_EN
    if (req0_valid && req1_valid) gnt_id = ~last_grant_q;
    else                          gnt_id = ~req0_valid;
`else
    gnt_id = ~req0_valid;
`endif
  end

  assign op_illegal = (op_q.ctrl > 3'd4);

  // ALU is driven straight from the op registers; illegal codes are parked on ADD.
  assign alu_a    = op_q.a;
  assign alu_b    = op_q.b;
  assign alu_ctrl = op_illegal ? 3'd0 : op_q.ctrl;

  // ---- FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---- FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (gnt_vld) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = gnt_vld ? EXEC : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs
  always_comb begin
    req0_ready = gnt_vld && !gnt_id;
    req1_ready = gnt_vld &&  gnt_id;
    rsp_valid  = (state_q == RESP);
  end

  // ---- op registers and response capture
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q         <= '0;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_flags    <= '0;
      rsp_err      <= 1'b0;
`ifdef ALU_SHARE_RR_EN
      last_grant_q <= 1'b1;  // so requester 0 wins the first contention
`endif
    end else begin
      if (gnt_vld) begin
        op_q.id   <= gnt_id;
        op_q.ctrl <= gnt_id ? req1_ctrl : req0_ctrl;
        op_q.a    <= gnt_id ? req1_a    : req0_a;
        op_q.b    <= gnt_id ? req1_b    : req0_b;
`ifdef ALU_SHARE_RR_EN
        last_grant_q <= gnt_id;
`endif
      end
      if (state_q == EXEC) begin
        rsp_id     <= op_q.id;
        rsp_result <= op_illegal ? 32'd0 : alu_result;
        rsp_flags  <= op_illegal ? 4'd0  : alu_flags;
        rsp_err    <= op_illegal;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
module tb_alu_share_arb;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_ctrl, req1_ctrl;
  logic        req0_ready, req1_ready;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [2:0]  alu_ctrl;
  logic [3:0]  alu_flags;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;

  int n_cmp  = 0;
  int n_fail = 0;

  alu_share_arb dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU: flags {N,Z,C,V}.
  logic [31:0] m_r;
  logic        m_c, m_v;
  always_comb begin
    m_r = '0;
    m_c = 1'b0;
    m_v = 1'b0;
    case (alu_ctrl)
      3'd0: begin
        {m_c, m_r} = {1'b0, alu_a} + {1'b0, alu_b};
        m_v = (alu_a[31] == alu_b[31]) && (m_r[31] != alu_a[31]);
      end
      3'd1: begin
        {m_c, m_r} = {1'b0, alu_a} - {1'b0, alu_b};
        m_v = (alu_a[31] != alu_b[31]) && (m_r[31] != alu_a[31]);
      end
      3'd2: m_r = alu_a & alu_b;
      3'd3: m_r = alu_a | alu_b;
      3'd4: m_r = alu_a * alu_b;
      default: m_r = '0;
    endcase
    alu_result = m_r;
    alu_flags  = {m_r[31], (m_r == 32'd0), m_c, m_v};
  end

  // Offer one op and wait (bounded) for its ready; returns just after the
  // grant edge, i.e. in the EXEC cycle, with valid dropped.
  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] ctrl);
    bit got;
    got = 1'b0;
    if (!id) begin
      req0_a = a; req0_b = b; req0_ctrl = ctrl; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_ctrl = ctrl; req1_valid = 1'b1;
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if ((!id && req0_ready) || (id && req1_ready)) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL grant_timeout id=%0d: ready never seen, want ready=1", id);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Consume the pending response on the next edge.
  task automatic retire();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h11; req0_b = 32'h22; req0_ctrl = 3'd0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_ctrl = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (req0_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req0_ready got=%b want=0", req0_ready); end
    n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req1_ready got=%b want=0", req1_ready); end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got=%b want=0", rsp_valid); end
    n_cmp++; if ({rsp_id, rsp_result, rsp_flags, rsp_err} !== 38'd0) begin
      n_fail++; $display("FAIL rst_rsp id=%b res=%h flg=%b err=%b want all 0", rsp_id, rsp_result, rsp_flags, rsp_err);
    end
    n_cmp++; if ({alu_a, alu_b, alu_ctrl} !== 67'd0) begin
      n_fail++; $display("FAIL rst_alu a=%h b=%h ctrl=%b want all 0", alu_a, alu_b, alu_ctrl);
    end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_single();
    issue(1'b0, 32'd5, 32'd7, 3'd0);
    @(negedge clk);  // EXEC
    n_cmp++; if ({alu_a, alu_b, alu_ctrl} !== {32'd5, 32'd7, 3'd0}) begin
      n_fail++; $display("FAIL single_alu a=%0d b=%0d ctrl=%b want 5 7 000", alu_a, alu_b, alu_ctrl);
    end
    n_cmp++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_exec_valid got=%b want=0", rsp_valid); end
    @(negedge clk);  // RESP: grant edge + 2
    n_cmp++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%b want=1", rsp_valid); end
    n_cmp++; if (rsp_result !== 32'd12) begin n_fail++; $display("FAIL single_result got=%0d want=12", rsp_result); end
    n_cmp++; if ({rsp_flags[2], rsp_id, rsp_err} !== 3'b000) begin
      n_fail++; $display("FAIL single_meta z=%b id=%b err=%b want 0 0 0", rsp_flags[2], rsp_id, rsp_err);
    end
    retire();
  endtask

  task automatic test_zero_flag();
    issue(1'b1, 32'hFFFF_FFFF, 32'd1, 3'd0);
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_result} !== {1'b1, 32'd0}) begin
      n_fail++; $display("FAIL zero_result valid=%b res=%h want 1 0", rsp_valid, rsp_result);
    end
    n_cmp++; if ({rsp_flags[2], rsp_id} !== 2'b11) begin
      n_fail++; $display("FAIL zero_flag z=%b id=%b want 1 1", rsp_flags[2], rsp_id);
    end
    retire();
    issue(1'b1, 32'd6, 32'd7, 3'd4);
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'd42}) begin
      n_fail++; $display("FAIL mul_result valid=%b id=%b res=%0d want 1 1 42", rsp_valid, rsp_id, rsp_result);
    end
    retire();
  endtask

  task automatic test_contention();
    int          cnt;
    int          idx_q[4];
    logic        id_q[4];
    logic [31:0] res_q[4];
    logic        exp_id;
    cnt = 0;
    req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 3'd0; req0_valid = 1'b1;  // 3
    req1_a = 32'd9; req1_b = 32'd4; req1_ctrl = 3'd1; req1_valid = 1'b1;  // 5
    rsp_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        if (cnt < 4) begin
          idx_q[cnt] = k; id_q[cnt] = rsp_id; res_q[cnt] = rsp_result;
        end
        cnt++;
      end
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL cont_count got=%0d want=4", cnt); end
    for (int i = 0; i < 4 && i < cnt; i++) begin
`ifdef ALU_SHARE_RR_EN
      exp_id = (i % 2 == 1);
`else
      exp_id = 1'b0;
`endif
      n_cmp++; if (idx_q[i] != 2 + 2 * i) begin
        n_fail++; $display("FAIL cont_spacing[%0d] got cycle=%0d want=%0d", i, idx_q[i], 2 + 2 * i);
      end
      n_cmp++; if (id_q[i] !== exp_id) begin
        n_fail++; $display("FAIL cont_id[%0d] got=%b want=%b", i, id_q[i], exp_id);
      end
      n_cmp++; if (res_q[i] !== (exp_id ? 32'd5 : 32'd3)) begin
        n_fail++; $display("FAIL cont_result[%0d] got=%0d want=%0d", i, res_q[i], exp_id ? 5 : 3);
      end
    end
  endtask

  task automatic test_back_pressure();
    int bad;
    issue(1'b0, 32'd10, 32'd3, 3'd1);
    req1_a = 32'hF0; req1_b = 32'h0F; req1_ctrl = 3'd3; req1_valid = 1'b1;
    @(negedge clk);  // EXEC: request must wait
    n_cmp++; if (req1_ready !== 1'b0) begin n_fail++; $display("FAIL bp_exec_ready got=%b want=0", req1_ready); end
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_id, rsp_result, rsp_err, req0_ready, req1_ready} !== {1'b1, 1'b0, 32'd7, 1'b0, 1'b0, 1'b0})
        bad++;
    end
    n_cmp++; if (bad != 0) begin
      n_fail++; $display("FAIL bp_hold unstable cycles=%0d want=0 (last valid=%b res=%0d r0=%b r1=%b)",
                         bad, rsp_valid, rsp_result, req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_cmp++; if ({req0_ready, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_release r0=%b r1=%b want 0 1", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    @(negedge clk); @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, 32'hFF}) begin
      n_fail++; $display("FAIL bp_next valid=%b id=%b res=%h want 1 1 ff", rsp_valid, rsp_id, rsp_result);
    end
    retire();
  endtask

  task automatic test_illegal_reset();
    int seen;
    issue(1'b0, 32'd3, 32'd4, 3'b110);
    @(negedge clk);
    n_cmp++; if ({alu_a, alu_ctrl} !== {32'd3, 3'd0}) begin
      n_fail++; $display("FAIL ill_alu a=%0d ctrl=%b want 3 000", alu_a, alu_ctrl);
    end
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_err, rsp_result, rsp_flags} !== {1'b1, 1'b1, 32'd0, 4'd0}) begin
      n_fail++; $display("FAIL ill_rsp valid=%b err=%b res=%h flg=%b want 1 1 0 0000",
                         rsp_valid, rsp_err, rsp_result, rsp_flags);
    end
    retire();
    issue(1'b0, 32'd1, 32'd1, 3'd0);
    reset = 1'b0;  // lands during EXEC
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_cmp++; if ({rsp_valid, rsp_err, alu_a} !== {1'b0, 1'b0, 32'd0}) begin
      n_fail++; $display("FAIL midexec_reset valid=%b err=%b alu_a=%0d want 0 0 0", rsp_valid, rsp_err, alu_a);
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL dropped_op responses=%0d want=0", seen); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_zero_flag();
    test_contention();
    test_back_pressure();
    test_illegal_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
